// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   state_t    : arbiter FSM states (IDLE, RESP)
//   port_idx_t : one-bit requester index (0 = core LSU, 1 = debug/loader)
//   addr_error : flags a misaligned or out-of-range byte address
package dmem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef logic port_idx_t;

    // Word accesses only: low two bits must be zero, and the address must
    // fall inside the 2**aw byte memory.
    function automatic logic addr_error(input logic [31:0] addr, input int unsigned aw);
        logic out_of_range;
        out_of_range = (addr >> aw) != 32'd0;
        return (addr[1:0] != 2'b00) || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the Data_memory bus.
//   reqN_*     : request from port N (valid/write/addr/wdata in, ready out)
//   respN_*    : one-cycle response pulse with error flag and load data
//   mem_*      : direct connection to Data_memory (one-cycle read latency)
// Handshake: a request transfers on the rising edge where reqN_valid and
// reqN_ready are both 1; the requester holds addr/write/wdata stable until
// then. respN_valid is a single-cycle pulse with no back-pressure.
interface dmem_arb_if import dmem_arb_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [31:0]           req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  resp0_valid;
    logic                  resp0_err;
    logic [DATA_WIDTH-1:0] resp0_rdata;

    logic                  req1_valid;
    logic                  req1_write;
    logic [31:0]           req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  resp1_valid;
    logic                  resp1_err;
    logic [DATA_WIDTH-1:0] resp1_rdata;

    logic [31:0]           mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_read_data;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_err, resp0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_err, resp1_rdata,
        output mem_address, mem_write_data, mem_write, mem_read,
        input  mem_read_data
    );

    // Requester / memory-model side.
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_err, resp0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_err, resp1_rdata,
        input  mem_address, mem_write_data, mem_write, mem_read,
        output mem_read_data
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin selector.
//   valid0_i, valid1_i : candidate requests
//   last_i             : port granted most recently
//   gnt_o              : one-hot grant (bit N = port N), 0 when nothing valid
module rr_arbiter2 import dmem_arb_pkg::*; (
    input  logic      valid0_i,
    input  logic      valid1_i,
    input  port_idx_t last_i,
    output logic [1:0] gnt_o
);

    // A lone requester always wins; on a tie the port not served last wins.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = valid0_i && (!valid1_i || (last_i == 1'b1));
        gnt_o[1] = valid1_i && (!valid0_i || (last_i == 1'b0));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-ported Data_memory.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester ports, responses and the Data_memory bus
//   state_o  : current FSM state, for observation
// One access is in flight at a time: a grant in IDLE drives the memory bus
// combinationally that cycle, and the response pulse follows in RESP while
// the memory returns read data. Both ready lines are 0 in RESP, so accept
// and response never coincide.
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    dmem_arb_if.slave  bus,
    output state_t     state_o
);

    state_t    state_q;
    port_idx_t last_q;
    logic [1:0] resp_valid_q;
    logic      err_q;
    logic      load_q;

    logic                  idle;
    logic [1:0]            gnt;
    logic                  gnt_any;
    logic                  sel_write;
    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_err;
    logic                  mem_go;

    // Gating with rst keeps every output at 0 while reset is held.
    assign idle = (state_q == IDLE) && !rst;

    rr_arbiter2 u_rr (
        .valid0_i (bus.req0_valid && idle),
        .valid1_i (bus.req1_valid && idle),
        .last_i   (last_q),
        .gnt_o    (gnt)
    );

    assign gnt_any   = |gnt;
    assign sel_write = gnt[1] ? bus.req1_write : bus.req0_write;
    assign sel_addr  = gnt[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = gnt[1] ? bus.req1_wdata : bus.req0_wdata;
    assign sel_err   = addr_error(sel_addr, ADDR_WIDTH);
    assign mem_go    = gnt_any && !sel_err;

    assign bus.req0_ready     = gnt[0];
    assign bus.req1_ready     = gnt[1];
    assign bus.mem_address    = mem_go ? sel_addr : 32'd0;
    assign bus.mem_write_data = mem_go ? sel_wdata : {DATA_WIDTH{1'b0}};
    assign bus.mem_write      = mem_go && sel_write;
    assign bus.mem_read       = mem_go && !sel_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;   // port 0 wins the first tie
            resp_valid_q <= 2'b00;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        state_q      <= RESP;
                        last_q       <= gnt[1];
                        resp_valid_q <= gnt;
                        err_q        <= sel_err;
                        load_q       <= !sel_write;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 2'b00;
                    err_q        <= 1'b0;
                    load_q       <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // mem_read_data is valid in RESP because the memory was read on the
    // grant edge; stores and errors return zero.
    assign bus.resp0_valid = resp_valid_q[0];
    assign bus.resp1_valid = resp_valid_q[1];
    assign bus.resp0_err   = resp_valid_q[0] && err_q;
    assign bus.resp1_err   = resp_valid_q[1] && err_q;
    assign bus.resp0_rdata = (resp_valid_q[0] && !err_q && load_q) ? bus.mem_read_data : {DATA_WIDTH{1'b0}};
    assign bus.resp1_rdata = (resp_valid_q[1] && !err_q && load_q) ? bus.mem_read_data : {DATA_WIDTH{1'b0}};

    assign state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int EW = 49;   // {accept cycle[15:0], err, rdata[31:0]}

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arb_if #(.DATA_WIDTH(DW)) bus();

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- Data_memory model (one-cycle read) ----------------
    logic [31:0] dev_mem [256];
    always @(posedge clk) begin
        if (bus.mem_write) dev_mem[bus.mem_address[9:2]] <= bus.mem_write_data;
        if (bus.mem_read)  bus.mem_read_data <= dev_mem[bus.mem_address[9:2]];
    end

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [31:0]   ref_mem [256];
    logic [EW-1:0] exp0_q[$];
    logic [EW-1:0] exp1_q[$];
    logic          busy_m = 1'b0;   // a response is due next cycle
    logic          last_m = 1'b1;   // port served most recently
    logic [1:0]    egnt;
    logic          sel_w, err_e;
    logic [31:0]   sel_a, sel_d, rd_e;
    logic [EW-1:0] ent;

    // Accept monitor: predicts who is granted and what the memory bus shows,
    // and pushes the expected response for each accepted request.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            chk("rst_membus", {bus.mem_address, bus.mem_write_data, bus.mem_write, bus.mem_read}, '0);
            busy_m = 1'b0;
            last_m = 1'b1;
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            egnt = 2'b00;
            if (!busy_m) begin
                if (bus.req0_valid && bus.req1_valid) egnt = last_m ? 2'b01 : 2'b10;
                else egnt = {bus.req1_valid, bus.req0_valid};
            end
            chk("grant", {bus.req1_ready, bus.req0_ready}, egnt);
            if (egnt != 2'b00) begin
                sel_w = egnt[1] ? bus.req1_write : bus.req0_write;
                sel_a = egnt[1] ? bus.req1_addr  : bus.req0_addr;
                sel_d = egnt[1] ? bus.req1_wdata : bus.req0_wdata;
                err_e = (sel_a[1:0] != 2'b00) || (sel_a >= 32'(1 << AW));
                if (err_e)
                    chk("membus_err", {bus.mem_address, bus.mem_write_data, bus.mem_write, bus.mem_read}, '0);
                else
                    chk("membus", {bus.mem_address, bus.mem_write_data, bus.mem_write, bus.mem_read},
                        {sel_a, sel_d, sel_w, !sel_w});
                rd_e = (!err_e && !sel_w) ? ref_mem[sel_a[9:2]] : 32'd0;
                if (!err_e && sel_w) ref_mem[sel_a[9:2]] = sel_d;
                ent = {16'(cyc), err_e, rd_e};
                if (egnt[1]) exp1_q.push_back(ent);
                else exp0_q.push_back(ent);
                busy_m = 1'b1;
                last_m = egnt[1];
            end else begin
                chk("membus_idle", {bus.mem_address, bus.mem_write_data, bus.mem_write, bus.mem_read}, '0);
                busy_m = 1'b0;
            end
        end
    end

    // Response monitor: pops and compares whenever a response is presented.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_resp", {bus.resp1_valid, bus.resp0_valid, bus.resp1_err, bus.resp0_err,
                             bus.resp1_rdata, bus.resp0_rdata}, '0);
        end else begin
            if (bus.resp0_valid || bus.resp1_valid)
                chk("resp_overlap", {bus.resp1_valid, bus.resp0_valid} == 2'b11, 1'b0);
            if (bus.resp0_valid) begin
                chk("resp0_expected", exp0_q.size() > 0, 1'b1);
                if (exp0_q.size() > 0) begin
                    ent = exp0_q.pop_front();
                    chk("resp0_latency", 16'(cyc), ent[48:33] + 16'd1);
                    chk("resp0_data", {bus.resp0_err, bus.resp0_rdata}, ent[32:0]);
                end
            end
            if (bus.resp1_valid) begin
                chk("resp1_expected", exp1_q.size() > 0, 1'b1);
                if (exp1_q.size() > 0) begin
                    ent = exp1_q.pop_front();
                    chk("resp1_latency", 16'(cyc), ent[48:33] + 16'd1);
                    chk("resp1_data", {bus.resp1_err, bus.resp1_rdata}, ent[32:0]);
                end
            end
            if (exp0_q.size() > 0 && int'(exp0_q[0][48:33]) + 1 < cyc) begin
                chk("resp0_missing", exp0_q[0][48:33], 16'(cyc - 1));
                void'(exp0_q.pop_front());
            end
            if (exp1_q.size() > 0 && int'(exp1_q[0][48:33]) + 1 < cyc) begin
                chk("resp1_missing", exp1_q[0][48:33], 16'(cyc - 1));
                void'(exp1_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int  n;
        logic rdy;
        if (p == 0) begin
            bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_valid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
        end while (!rdy && n < 100);
        if (!rdy) chk("req_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        if (p == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        else if (r == 7) return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (r == 8) return 32'h400 + 32'($urandom_range(0, 255) * 4);
        else             return $urandom;
    endfunction

    task automatic rand_stream(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            gap($urandom_range(0, 2));
            drive(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 32'(i) * 32'h01010101;
            ref_mem[i] = 32'(i) * 32'h01010101;
        end
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        rst = 1'b1;
        #1;
        // Requests held during reset must not be accepted.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        rst = 1'b0;

        // Store then load on port 0; the first edge after release accepts.
        drive(0, 1'b1, 32'h010, 32'hDEADBEEF);
        drive(0, 1'b0, 32'h010, 32'h0);
        gap(2);

        // Port 1 errors: misaligned load, out-of-range store.
        drive(1, 1'b0, 32'h013, 32'h0);
        drive(1, 1'b1, 32'h400, 32'h12345678);
        gap(2);

        // Contention: both ports continuously valid, grants must alternate.
        fork
            for (int i = 0; i < 4; i++) drive(0, 1'b0, 32'h020, 32'h0);
            for (int i = 0; i < 4; i++) drive(1, 1'b0, 32'h024, 32'h0);
        join
        gap(2);

        // Back-to-back stores then readback on port 1.
        for (int i = 0; i < 4; i++) drive(1, 1'b1, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 4; i++) drive(1, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
        gap(2);

        // Reset during RESP drops the response; port 0 wins the next tie.
        drive(0, 1'b0, 32'h010, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            drive(0, 1'b0, 32'h100, 32'h0);
            drive(1, 1'b0, 32'h104, 32'h0);
        join
        gap(2);

        // Randomised traffic on both ports.
        fork
            rand_stream(0, 40);
            rand_stream(1, 40);
        join
        gap(4);

        chk("drain0", exp0_q.size(), 0);
        chk("drain1", exp1_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the byte-address width of the shared Data_memory (1024 bytes).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 reqN_valid  input  1  request from port N (N=0 core LSU, N=1 debug/loader).
REQ-006 reqN_write  input  1  1=store, 0=load.
REQ-007 reqN_addr  input  32  byte address.
REQ-008 reqN_wdata  input  DATA_WIDTH  store data.
REQ-009 reqN_ready  output  1  request accepted this cycle.
REQ-010 respN_valid  output  1  one-cycle response pulse.
REQ-011 respN_err  output  1  misaligned or out-of-range access.
REQ-012 respN_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
REQ-013 mem_address  output  32; mem_write_data  output  DATA_WIDTH; mem_write  output  1; mem_read  output  1; mem_read_data  input  DATA_WIDTH. These SHALL connect directly to Data_memory.

Function
REQ-014 FSM states SHALL be IDLE and RESP; the FSM SHALL go IDLE->RESP on any grant and RESP->IDLE unconditionally.
REQ-015 Grant SHALL occur only in IDLE; reqN_ready SHALL be combinational, and 1 only for the granted port.
REQ-016 Arbitration: if one port is valid, it SHALL be granted; if both are valid, the port not granted last SHALL win (round-robin); after reset the last-grant pointer SHALL select port 0 as winner.
REQ-017 Transfer rule: a request SHALL complete when valid && ready; the requester SHALL hold addr/write/wdata stable until then.
REQ-018 Error check: addr[1:0]!=0 or addr>=2**ADDR_WIDTH SHALL flag an error; an errored grant SHALL assert neither mem_write nor mem_read.
REQ-019 For a non-error grant in cycle T, the block SHALL drive mem_address=addr and mem_write_data=wdata in T, with mem_write=write and mem_read=!write.
REQ-020 When no grant is made, mem_write and mem_read SHALL be 0, and mem_address and mem_write_data SHALL be 0.
REQ-021 In RESP (cycle T+1), respN_valid SHALL be 1 for the granted port only, and respN_err SHALL equal the registered error flag.
REQ-022 In RESP, respN_rdata SHALL equal mem_read_data for a non-error load, else 0 (Data_memory read latency is one cycle).
REQ-023 Latency SHALL be exactly 1 cycle from accept to response; peak throughput SHALL be one access per 2 cycles.
REQ-024 A port that is refused SHALL keep waiting; with both ports continuously valid, grants SHALL strictly alternate, so neither port starves.
REQ-025 Simultaneous accept and response on the same cycle SHALL be impossible by construction, since ready=0 in RESP.

Reset
REQ-026 On rst=1, the FSM SHALL go to IDLE and the last-grant pointer SHALL select port 0 as the next winner, both immediately.
REQ-027 On rst=1, all outputs SHALL be 0.
REQ-028 A reset asserted in RESP SHALL drop the pending response; no respN_valid SHALL follow release.
REQ-029 After rst deasserts, the first rising edge SHALL be able to accept a request.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold: the state enum (IDLE, RESP), the port-index typedef (1 bit), and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-031 Round-robin selection SHALL live in sub-module rr_arbiter2 (inputs: two valids, the last-grant pointer; outputs: one-hot grant); the rest SHALL stay in dmem_arbiter.

Verification
REQ-032 Store then load: port0 writes 0xDEADBEEF to 0x010, then reads 0x010 -> mem_write pulses once; resp0_valid one cycle after each accept; read returns rdata=0xDEADBEEF, err=0.
REQ-033 Contention: both ports are valid for 8 cycles (port0 read 0x020, port1 read 0x024) -> grants go 0,1,0,1 at cycles 0,2,4,6; no resp1 during port0's response.
REQ-034 Errors: port1 load from 0x013 and store to 0x400 -> resp1_err=1, rdata=0, and mem_read/mem_write stay 0 throughout.
REQ-035 Reset mid-op: port0 load is accepted, rst pulses during RESP -> no resp0_valid; after release, port0 is granted first when both are valid.
REQ-036 Back-to-back: port1 issues 4 consecutive stores to 0x100..0x10C, then reads them back -> ready is high on every second cycle, and readback matches the written data.
